// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and helpers for the bit-serial adder: FSM state
//               encoding, maximum operand width and bit-counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  // Widest operand the adder is intended to be built for.
  localparam int MAX_WIDTH = 32;

  // Control FSM states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width: enough to index bits 0..w-1 (never narrower than 1).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_cell
// Description : One-bit combinational full adder; the single slice that the
//               serial adder reuses on every RUN cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic S,
  output logic C_out
);

  // Sum is odd parity of the three inputs; carry is their majority.
  always_comb begin
    S     = A ^ B ^ C_in;
    C_out = (A & B) | (A & C_in) | (B & C_in);
  end

endmodule : full_adder_cell
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder. One full-adder slice processes
//               the operands LSB first, one bit per clock, with the carry
//               held in a flop between bits. start/busy/done handshake;
//               S and C_out update only on entry to DONE.
//               Optional macro SERIAL_ADDER_OVF_EN adds a registered signed
//               overflow output OVF.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  // The accumulator only needs WIDTH-1 bits: the final sum bit is joined
  // to it directly when the result is captured into S.
  logic [WIDTH-2:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               c_out_q, c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               sum_bit;
  logic               carry_next;
  logic [WIDTH-1:0]   acc_shift;

  full_adder_cell u_fa (
    .A     (a_q[0]),
    .B     (b_q[0]),
    .C_in  (carry_q),
    .S     (sum_bit),
    .C_out (carry_next)
  );

  // New sum bit enters at the top; after the last bit this is the full sum.
  always_comb begin
    acc_shift = {sum_bit, acc_q};
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_out_d = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = C_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_shift[WIDTH-1:1];
        carry_d = carry_next;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == LAST_BIT) begin
          // Result registers load together with the move into DONE so a
          // partial sum never reaches S.
          s_d     = acc_shift;
          c_out_d = carry_next;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB while bit WIDTH-1 is processed.
          ovf_d   = carry_q ^ carry_next;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    S     = s_q;
    C_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    OVF   = ovf_q;
`endif
  end

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard testbench for serial_adder. The driver pushes the
//               expected sum (from plain integer arithmetic) and the cycle on
//               which done must appear; a monitor pops and compares on done.
//               Honours SERIAL_ADDER_OVF_EN for the OVF output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             OVF;
`endif

  exp_t             sb[$];
  exp_t             mon_e;
  int               checks     = 0;
  int               failures   = 0;
  int               cyc        = 0;
  int               done_count = 0;
  int               exp_done   = 0;
  logic             prev_done  = 1'b0;
  logic [WIDTH-1:0] last_s     = '0;
  logic             last_c     = 1'b0;
  logic             last_ovf   = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .C_out (C_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: unsigned sum with one extra bit for the carry; signed
  // overflow when both operands share a sign the result does not.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci, input int due);
    exp_t             m;
    logic [WIDTH:0]   sum;
    sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    m.s   = sum[WIDTH-1:0];
    m.c   = sum[WIDTH];
    m.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    m.cyc = due;
    return m;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_count++;
        chk("done_not_consecutive", {63'd0, prev_done}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 required no pending result");
        end else begin
          mon_e = sb.pop_front();
          chk("sum_S", S, mon_e.s);
          chk("carry_C_out", C_out, mon_e.c);
`ifdef SERIAL_ADDER_OVF_EN
          chk("overflow_OVF", OVF, mon_e.ovf);
`endif
          chk("done_latency_cycle", cyc, mon_e.cyc);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Issue one operation; optionally re-pulse start during RUN or reset mid-run.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input int restart_at, input int reset_at);
    exp_t e;
    int   nb;
    logic aborted;
    @(negedge clk);
    A = a; B = b; C_in = ci; start = 1'b1;
    e = model(a, b, ci, cyc + 1 + WIDTH);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A = WIDTH'($urandom); B = WIDTH'($urandom); C_in = 1'($urandom);
    nb = 0;
    aborted = 1'b0;
    while (busy && nb <= 3 * WIDTH) begin
      nb++;
      if (!done) chk("S_holds_previous", S, last_s);
      if (nb == reset_at) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_S", S, 0);
        chk("abort_C_out", C_out, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("abort_OVF", OVF, 0);
`endif
        void'(sb.pop_back());
        aborted = 1'b1;
        last_s = '0; last_c = 1'b0; last_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      start = (nb == restart_at);
      if (nb == restart_at) begin
        A = 'd1; B = 'd1; C_in = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!aborted) begin
      exp_done++;
      chk("busy_cycles", nb, WIDTH + 1);
      chk("S_after_done", S, e.s);
      chk("C_out_after_done", C_out, e.c);
      last_s = e.s; last_c = e.c; last_ovf = e.ovf;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; C_in = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_S", S, 0);
    chk("reset_C_out", C_out, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset_OVF", OVF, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(8'h3C, 8'h11, 1'b0, 0, 0);  // basic sum
    run_op(8'hFF, 8'h01, 1'b0, 0, 0);  // unsigned wrap
    run_op(8'h7F, 8'h01, 1'b0, 0, 0);  // signed overflow
    run_op(8'hFF, 8'hFF, 1'b1, 0, 0);  // carry-in, max operands
    run_op(8'h5A, 8'h33, 1'b1, 3, 0);  // start re-pulsed during RUN
    run_op(8'hA5, 8'h6C, 1'b0, 0, 4);  // reset four cycles into RUN
    repeat (2 * WIDTH) @(negedge clk); // any stray done is flagged by the monitor
    run_op(8'h80, 8'h80, 1'b0, 0, 0);  // fresh operation after reset
    for (int i = 0; i < 24; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, 0);
    end
    repeat (4) @(negedge clk);

    chk("done_pulse_count", done_count, exp_done);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so a stuck DUT cannot hang the run.
  initial begin
    #500000;
    $display("FAIL timeout: got no completion required finish within bound");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_adder
`default_nettype wire
